// File: rtl/sargantana_icache_pkg.sv
// Shared geometry constants and controller state type for the I-cache tag path.
package sargantana_icache_pkg;

  localparam int ICACHE_N_WAY = 4;
  localparam int ICACHE_DEPTH = 64;
  localparam int IDX_WIDTH    = $clog2(ICACHE_DEPTH);
`ifdef PADDR_39
  localparam int TAG_WIDHT    = 27;
`else
  localparam int TAG_WIDHT    = 20;
`endif
  localparam int RR_WIDTH     = (ICACHE_N_WAY > 1) ? $clog2(ICACHE_N_WAY) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOOKUP = 1'b1
  } tag_ctrl_state_t;

endpackage

// File: rtl/sargantana_icache_victim_sel.sv
// Victim way picker: lowest invalid way, otherwise the round-robin pointer as one-hot.
module sargantana_icache_victim_sel
  import sargantana_icache_pkg::*;
#(
  parameter int N_WAY = ICACHE_N_WAY,
  parameter int PTR_W = RR_WIDTH
) (
  input  logic [N_WAY-1:0] vbit,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N_WAY-1:0] victim
);

  logic [N_WAY:0]   free_seen;
  logic [N_WAY-1:0] first_free;
  logic [N_WAY-1:0] rr_onehot;

  assign free_seen[0] = 1'b0;

  // free_seen[w] says some lower-index way is already free.
  generate
    for (genvar gi = 0; gi < N_WAY; gi++) begin : g_way
      assign first_free[gi]  = ~vbit[gi] & ~free_seen[gi];
      assign free_seen[gi+1] = free_seen[gi] | ~vbit[gi];
      assign rr_onehot[gi]   = (rr_ptr == PTR_W'(gi));
    end
  endgenerate

  assign victim = free_seen[N_WAY] ? first_free : rr_onehot;

endmodule

// File: rtl/sargantana_icache_tag_ctrl.sv
// I-cache tag array controller: lookups with one-cycle compare, refill writes and flushes.
module sargantana_icache_tag_ctrl
  import sargantana_icache_pkg::*;
(
  input  logic                                   clk_i,
  input  logic                                   rstn_i,
  input  logic                                   lookup_valid_i,
  output logic                                   lookup_ready_o,
  input  logic [IDX_WIDTH-1:0]                   lookup_idx_i,
  input  logic [TAG_WIDHT-1:0]                   lookup_tag_i,
  output logic                                   resp_valid_o,
  output logic                                   resp_hit_o,
  output logic [ICACHE_N_WAY-1:0]                resp_hit_way_o,
  output logic [ICACHE_N_WAY-1:0]                resp_victim_way_o,
  input  logic                                   refill_valid_i,
  input  logic [ICACHE_N_WAY-1:0]                refill_way_i,
  input  logic [IDX_WIDTH-1:0]                   refill_idx_i,
  input  logic [TAG_WIDHT-1:0]                   refill_tag_i,
  output logic                                   refill_ack_o,
  input  logic                                   flush_i,
  output logic [ICACHE_N_WAY-1:0]                tmem_req_o,
  output logic                                   tmem_we_o,
  output logic                                   tmem_vbit_o,
  output logic                                   tmem_flush_o,
  output logic [TAG_WIDHT-1:0]                   tmem_data_o,
  output logic [IDX_WIDTH-1:0]                   tmem_addr_o,
  input  logic [ICACHE_N_WAY-1:0][TAG_WIDHT-1:0] tmem_tag_way_i,
  input  logic [ICACHE_N_WAY-1:0]                tmem_vbit_i
);

  tag_ctrl_state_t      state_reg;
  logic [IDX_WIDTH-1:0] lat_idx_reg;
  logic [TAG_WIDHT-1:0] lat_tag_reg;
  logic [RR_WIDTH-1:0]  rr_ptr_reg;

  logic in_idle;
  logic in_lookup;
  logic lookup_fire;
  logic [ICACHE_N_WAY-1:0] hv;
  logic [ICACHE_N_WAY:0]   hit_seen;
  logic [ICACHE_N_WAY-1:0] hit_lowest;
  logic [ICACHE_N_WAY-1:0] victim;

  // Outputs are combinational, so every one is gated by rstn_i to read 0 in reset.
  assign in_idle        = rstn_i & (state_reg == IDLE);
  assign in_lookup      = rstn_i & (state_reg == LOOKUP);
  assign tmem_flush_o   = rstn_i & flush_i;
  assign refill_ack_o   = in_idle & ~flush_i & refill_valid_i;
  assign lookup_ready_o = in_idle & ~flush_i & ~refill_valid_i;
  assign lookup_fire    = lookup_ready_o & lookup_valid_i;

  assign tmem_req_o  = refill_ack_o ? refill_way_i :
                       lookup_fire  ? {ICACHE_N_WAY{1'b1}} : '0;
  assign tmem_we_o   = refill_ack_o;
  assign tmem_vbit_o = refill_ack_o;
  assign tmem_data_o = refill_ack_o ? refill_tag_i : '0;
  assign tmem_addr_o = refill_ack_o ? refill_idx_i :
                       lookup_fire  ? lookup_idx_i :
                       in_lookup    ? lat_idx_reg  : '0;

  assign hit_seen[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < ICACHE_N_WAY; gi++) begin : g_cmp
      assign hv[gi]           = tmem_vbit_i[gi] & (tmem_tag_way_i[gi] == lat_tag_reg);
      assign hit_lowest[gi]   = hv[gi] & ~hit_seen[gi];
      assign hit_seen[gi+1]   = hit_seen[gi] | hv[gi];
    end
  endgenerate

  sargantana_icache_victim_sel #(
    .N_WAY (ICACHE_N_WAY),
    .PTR_W (RR_WIDTH)
  ) u_victim_sel (
    .vbit   (tmem_vbit_i),
    .rr_ptr (rr_ptr_reg),
    .victim (victim)
  );

  // A flush during the compare cycle aborts the lookup, so no response escapes.
  assign resp_valid_o      = in_lookup & ~flush_i;
  assign resp_hit_o        = resp_valid_o & hit_seen[ICACHE_N_WAY];
  assign resp_hit_way_o    = resp_valid_o ? hit_lowest : '0;
  assign resp_victim_way_o = resp_valid_o ? victim : '0;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg   <= IDLE;
      lat_idx_reg <= '0;
      lat_tag_reg <= '0;
      rr_ptr_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (lookup_fire) begin
            state_reg   <= LOOKUP;
            lat_idx_reg <= lookup_idx_i;
            lat_tag_reg <= lookup_tag_i;
          end
          if (refill_ack_o && (refill_way_i != '0)) begin
            rr_ptr_reg <= rr_ptr_reg + 1'b1;
          end
        end
        LOOKUP:  state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sargantana_icache_tag_ctrl.sv
// Randomized bench: tag memory model on the tmem pins, cache-level reference model for responses.
module tb_sargantana_icache_tag_ctrl;
  import sargantana_icache_pkg::*;

  localparam int N = ICACHE_N_WAY;
  localparam int D = ICACHE_DEPTH;

  logic clk_i = 1'b0;
  logic rstn_i = 1'b0;
  logic lookup_valid_i = 1'b0;
  logic lookup_ready_o;
  logic [IDX_WIDTH-1:0] lookup_idx_i = '0;
  logic [TAG_WIDHT-1:0] lookup_tag_i = '0;
  logic resp_valid_o, resp_hit_o;
  logic [N-1:0] resp_hit_way_o, resp_victim_way_o;
  logic refill_valid_i = 1'b0;
  logic [N-1:0] refill_way_i = '0;
  logic [IDX_WIDTH-1:0] refill_idx_i = '0;
  logic [TAG_WIDHT-1:0] refill_tag_i = '0;
  logic refill_ack_o;
  logic flush_i = 1'b0;
  logic [N-1:0] tmem_req_o;
  logic tmem_we_o, tmem_vbit_o, tmem_flush_o;
  logic [TAG_WIDHT-1:0] tmem_data_o;
  logic [IDX_WIDTH-1:0] tmem_addr_o;
  logic [N-1:0][TAG_WIDHT-1:0] tmem_tag_way_i = '0;
  logic [N-1:0] tmem_vbit_i = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  sargantana_icache_tag_ctrl dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .lookup_valid_i(lookup_valid_i), .lookup_ready_o(lookup_ready_o),
    .lookup_idx_i(lookup_idx_i), .lookup_tag_i(lookup_tag_i),
    .resp_valid_o(resp_valid_o), .resp_hit_o(resp_hit_o),
    .resp_hit_way_o(resp_hit_way_o), .resp_victim_way_o(resp_victim_way_o),
    .refill_valid_i(refill_valid_i), .refill_way_i(refill_way_i),
    .refill_idx_i(refill_idx_i), .refill_tag_i(refill_tag_i),
    .refill_ack_o(refill_ack_o), .flush_i(flush_i),
    .tmem_req_o(tmem_req_o), .tmem_we_o(tmem_we_o), .tmem_vbit_o(tmem_vbit_o),
    .tmem_flush_o(tmem_flush_o), .tmem_data_o(tmem_data_o), .tmem_addr_o(tmem_addr_o),
    .tmem_tag_way_i(tmem_tag_way_i), .tmem_vbit_i(tmem_vbit_i)
  );

  // Tag memory model: reacts only to the tmem pins, registered read.
  logic [TAG_WIDHT-1:0] mem_tag [N][D];
  logic                 mem_v   [N][D];

  initial begin
    for (int w = 0; w < N; w++)
      for (int i = 0; i < D; i++) begin
        mem_tag[w][i] = '0;
        mem_v[w][i]   = 1'b0;
      end
  end

  always @(posedge clk_i) begin
    if (tmem_flush_o) begin
      for (int w = 0; w < N; w++)
        for (int i = 0; i < D; i++) mem_v[w][i] <= 1'b0;
    end else begin
      for (int w = 0; w < N; w++) begin
        if (tmem_req_o[w] && tmem_we_o) begin
          mem_tag[w][tmem_addr_o] <= tmem_data_o;
          mem_v[w][tmem_addr_o]   <= tmem_vbit_o;
        end
        if (tmem_req_o[w] && !tmem_we_o) begin
          tmem_tag_way_i[w] <= mem_tag[w][tmem_addr_o];
          tmem_vbit_i[w]    <= mem_v[w][tmem_addr_o];
        end
      end
    end
  end

  // Reference cache state, updated only from the stimulus the bench issues.
  logic [TAG_WIDHT-1:0] ref_tag [N][D];
  logic                 ref_v   [N][D];
  int                   refills_done = 0;

  task automatic ref_clear();
    for (int w = 0; w < N; w++)
      for (int i = 0; i < D; i++) ref_v[w][i] = 1'b0;
  endtask

  task automatic ref_expect(input int idx, input logic [TAG_WIDHT-1:0] tag,
                            output logic hit, output logic [N-1:0] hway,
                            output logic [N-1:0] victim);
    int free_w;
    hit = 1'b0; hway = '0; free_w = -1;
    for (int w = 0; w < N; w++) begin
      if (!hit && ref_v[w][idx] && ref_tag[w][idx] == tag) begin
        hit = 1'b1;
        hway = N'(1) << w;
      end
      if (free_w < 0 && !ref_v[w][idx]) free_w = w;
    end
    victim = (free_w >= 0) ? (N'(1) << free_w) : (N'(1) << (refills_done % N));
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({lookup_ready_o, resp_valid_o, resp_hit_o, resp_hit_way_o, resp_victim_way_o,
                refill_ack_o, tmem_req_o, tmem_we_o, tmem_vbit_o, tmem_flush_o,
                tmem_data_o, tmem_addr_o});
  endfunction

  // All transaction tasks start and end at posedge + #1.
  task automatic do_refill(input logic [N-1:0] way, input int idx, input logic [TAG_WIDHT-1:0] tag);
    refill_valid_i = 1'b1; refill_way_i = way;
    refill_idx_i = IDX_WIDTH'(idx); refill_tag_i = tag;
    @(negedge clk_i);
    check("refill_ack", refill_ack_o, 1);
    check("refill_ready", lookup_ready_o, 0);
    check("refill_req", tmem_req_o, way);
    check("refill_we_vbit", {tmem_we_o, tmem_vbit_o}, 2'b11);
    check("refill_data", tmem_data_o, tag);
    check("refill_addr", tmem_addr_o, idx);
    @(posedge clk_i);
    for (int w = 0; w < N; w++)
      if (way[w]) begin
        ref_v[w][idx] = 1'b1;
        ref_tag[w][idx] = tag;
      end
    if (way != '0) refills_done++;
    #1 refill_valid_i = 1'b0;
    $display("refill way=%b idx=%0d tag=%0h", way, idx, tag);
  endtask

  task automatic do_lookup(input int idx, input logic [TAG_WIDHT-1:0] tag, input bit abort);
    logic e_hit;
    logic [N-1:0] e_hway, e_vict;
    ref_expect(idx, tag, e_hit, e_hway, e_vict);
    lookup_valid_i = 1'b1; lookup_idx_i = IDX_WIDTH'(idx); lookup_tag_i = tag;
    @(negedge clk_i);
    check("lk_ready", lookup_ready_o, 1);
    check("lk_req", tmem_req_o, {N{1'b1}});
    check("lk_we", tmem_we_o, 0);
    check("lk_addr", tmem_addr_o, idx);
    check("lk_no_early_resp", resp_valid_o, 0);
    @(posedge clk_i);
    #1 lookup_valid_i = 1'b0;
    flush_i = abort;
    refill_valid_i = abort;
    refill_way_i = 4'b0001;
    @(negedge clk_i);
    check("cmp_ready", lookup_ready_o, 0);
    check("cmp_req", tmem_req_o, 0);
    if (abort) begin
      check("abort_resp", resp_valid_o, 0);
      check("abort_flush", tmem_flush_o, 1);
      check("abort_refill_wait", refill_ack_o, 0);
    end else begin
      check("resp_valid", resp_valid_o, 1);
      check("resp_hit", resp_hit_o, e_hit);
      check("resp_hit_way", resp_hit_way_o, e_hway);
      check("resp_victim", resp_victim_way_o, e_vict);
    end
    @(posedge clk_i);
    if (abort) ref_clear();
    #1 flush_i = 1'b0; refill_valid_i = 1'b0;
    $display("lookup idx=%0d tag=%0h abort=%0d exp_hit=%0d way=%b victim=%b",
             idx, tag, abort, e_hit, e_hway, e_vict);
  endtask

  task automatic do_flush();
    flush_i = 1'b1;
    @(negedge clk_i);
    check("flush_pin", tmem_flush_o, 1);
    check("flush_req", tmem_req_o, 0);
    check("flush_ready", lookup_ready_o, 0);
    @(posedge clk_i);
    ref_clear();
    #1 flush_i = 1'b0;
    $display("flush");
  endtask

  initial begin
    logic [N-1:0] rway;
    ref_clear();
    for (int w = 0; w < N; w++)
      for (int i = 0; i < D; i++) ref_tag[w][i] = '0;

    // Outputs must be quiet in reset even with requests asserted.
    lookup_valid_i = 1'b1; flush_i = 1'b1; refill_valid_i = 1'b1; refill_way_i = 4'b1111;
    #12;
    check("reset_outs", all_outs(), 0);
    @(posedge clk_i);
    #1 lookup_valid_i = 1'b0; flush_i = 1'b0; refill_valid_i = 1'b0; refill_way_i = '0;
    rstn_i = 1'b1;
    @(negedge clk_i);
    check("post_reset_ready", lookup_ready_o, 1);
    @(posedge clk_i); #1;
    $display("reset released");

    do_lookup(5, 'hABCDE, 0);
    do_refill(4'b0100, 5, 'hABCDE);
    do_lookup(5, 'hABCDE, 0);
    for (int w = 0; w < N; w++) do_refill(N'(1) << w, 9, TAG_WIDHT'('h100 + w));
    do_lookup(9, 'h55555, 0);
    do_refill(4'b0000, 9, 'h77777);
    do_lookup(9, 'h55555, 0);
    do_refill(4'b0010, 9, 'h101);
    do_lookup(9, 'h101, 0);
    do_lookup(9, 'h101, 1);
    do_lookup(5, 'hABCDE, 0);

    // Flush, refill and lookup together: one per cycle in priority order.
    refill_valid_i = 1'b1; refill_way_i = 4'b1000; refill_idx_i = 7; refill_tag_i = 'h33;
    lookup_valid_i = 1'b1; lookup_idx_i = 7; lookup_tag_i = 'h33; flush_i = 1'b1;
    @(negedge clk_i);
    check("pri_flush", {tmem_flush_o, refill_ack_o, lookup_ready_o, tmem_req_o}, 7'b1000000);
    @(posedge clk_i); ref_clear();
    #1 flush_i = 1'b0;
    @(negedge clk_i);
    check("pri_refill", {refill_ack_o, lookup_ready_o, tmem_req_o}, 6'b101000);
    @(posedge clk_i); ref_v[3][7] = 1'b1; ref_tag[3][7] = 'h33; refills_done++;
    #1 refill_valid_i = 1'b0; lookup_valid_i = 1'b0;
    $display("priority flush>refill>lookup");
    do_lookup(7, 'h33, 0);

    // Reset during the compare cycle.
    lookup_valid_i = 1'b1; lookup_idx_i = 2; lookup_tag_i = 'h9;
    @(posedge clk_i);
    #1 lookup_valid_i = 1'b0; rstn_i = 1'b0; flush_i = 1'b1; refill_valid_i = 1'b1;
    refills_done = 0;
    #1 check("rst_in_lookup_outs", all_outs(), 0);
    @(posedge clk_i);
    #1 flush_i = 1'b0; refill_valid_i = 1'b0; rstn_i = 1'b1;
    @(negedge clk_i);
    check("rst_no_resp", resp_valid_o, 0);
    check("rst_idle_ready", lookup_ready_o, 1);
    @(posedge clk_i); #1;
    $display("reset during lookup");
    for (int w = 0; w < N; w++) do_refill(N'(1) << w, 12, TAG_WIDHT'(w));
    do_lookup(12, 'hFFF, 0);

    for (int it = 0; it < 200; it++) begin
      int op;
      op = int'($urandom_range(0, 19));
      if (op == 0) do_flush();
      else if (op < 8) begin
        rway = N'($urandom_range(0, 15));
        do_refill(rway, int'($urandom_range(0, 3)), TAG_WIDHT'($urandom_range(0, 3)));
      end else
        do_lookup(int'($urandom_range(0, 3)), TAG_WIDHT'($urandom_range(0, 3)), (op == 19));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
